// File: rtl/fractcam_upd_ctrl_if.sv
// fractcam_upd_ctrl_if: requester handshakes and core-side bus of the FRACTCAM front end
interface fractcam_upd_ctrl_if #(
  parameter int key_size = 40,
  parameter int SN = 4,
  parameter int BW = $clog2(SN)
);
  logic s_valid, s_ready, u_valid, u_ready;
  logic we, srch_issue, upd_done, busy;
  logic [key_size-1:0] s_key, u_rule, u_mask, key, wr_rule, wr_mask;
  logic [SN-1:0] sel;
  logic [BW-1:0] u_blk;
  modport master (
    output s_valid, s_key, u_valid, u_blk, u_rule, u_mask,
    input  s_ready, u_ready, key, sel, we, wr_rule, wr_mask, srch_issue, upd_done, busy
  );
  modport slave (
    input  s_valid, s_key, u_valid, u_blk, u_rule, u_mask,
    output s_ready, u_ready, key, sel, we, wr_rule, wr_mask, srch_issue, upd_done, busy
  );
endinterface

// File: rtl/fractcam_upd_ctrl.sv
// fractcam_upd_ctrl: search/update arbiter and LUT-rewrite sequencer for the FRACTCAM core
module fractcam_upd_ctrl #(
  parameter int key_size = 40,
  parameter int SN = 4,
  parameter int LW = 5,
  parameter int SRCH_LAT = 3,
  parameter int BW = $clog2(SN)
) (
  input logic clk,
  input logic reset,
  fractcam_upd_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, WRITE = 2'd2;
  localparam logic [LW-1:0] CNT_MAX = '1;
  logic [1:0] state_q, state_d;
  logic pri_upd_q, pri_upd_d, we_q, we_d, issue_q, issue_d, done_q, done_d;
  logic [key_size-1:0] key_q, key_d, wr_rule_q, wr_rule_d, wr_mask_q, wr_mask_d;
  logic [SN-1:0] sel_q, sel_d, blk_sel;
  logic [BW-1:0] blk_q, blk_d;
  logic [LW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [SRCH_LAT-1:0] infl_q, infl_d;
  logic s_ready, u_ready, s_acc, u_acc, drained;
  assign s_ready = reset && state_q == IDLE && !(bus.u_valid && pri_upd_q);
  assign u_ready = reset && state_q == IDLE && bus.u_valid && (pri_upd_q || !bus.s_valid);
  assign s_acc = bus.s_valid && s_ready;
  assign u_acc = bus.u_valid && u_ready;
  assign drained = infl_q == '0 && !issue_q;
  assign cnt_inc = cnt_q + LW'(1);
  assign blk_sel = 32'(blk_q) < SN ? SN'(1) << blk_q : '0;
  // next-state: searches issue from IDLE, updates drain then sweep every LUT address
  always_comb begin
    state_d = u_acc ? DRAIN : state_q;
    pri_upd_d = s_acc ? 1'b1 : u_acc ? 1'b0 : pri_upd_q;
    key_d = s_acc ? bus.s_key : key_q;
    wr_rule_d = u_acc ? bus.u_rule : wr_rule_q;
    wr_mask_d = u_acc ? bus.u_mask : wr_mask_q;
    blk_d = u_acc ? bus.u_blk : blk_q;
    sel_d = sel_q;
    we_d = we_q;
    cnt_d = cnt_q;
    issue_d = s_acc;
    done_d = 1'b0;
    infl_d = (infl_q << 1) | SRCH_LAT'(issue_q);
    if (state_q == DRAIN && drained) begin
      state_d = WRITE;
      cnt_d = '0;
      key_d = '0;
      we_d = 1'b1;
      sel_d = blk_sel;
    end
    if (state_q == WRITE) begin
      state_d = cnt_q == CNT_MAX ? IDLE : WRITE;
      we_d = cnt_q != CNT_MAX;
      sel_d = cnt_q == CNT_MAX ? '0 : sel_q;
      done_d = cnt_q == CNT_MAX;
      cnt_d = cnt_inc;
      key_d = cnt_q == CNT_MAX ? key_q : {(key_size/LW){cnt_inc}};
    end
  end
  // state and registered outputs; reset aborts any update in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pri_upd_q <= 1'b0;
      key_q <= '0;
      wr_rule_q <= '0;
      wr_mask_q <= '0;
      blk_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      cnt_q <= '0;
      issue_q <= 1'b0;
      done_q <= 1'b0;
      infl_q <= '0;
    end else begin
      state_q <= state_d;
      pri_upd_q <= pri_upd_d;
      key_q <= key_d;
      wr_rule_q <= wr_rule_d;
      wr_mask_q <= wr_mask_d;
      blk_q <= blk_d;
      sel_q <= sel_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      issue_q <= issue_d;
      done_q <= done_d;
      infl_q <= infl_d;
    end
  end
  assign bus.s_ready = s_ready;
  assign bus.u_ready = u_ready;
  assign bus.key = key_q;
  assign bus.sel = sel_q;
  assign bus.we = we_q;
  assign bus.wr_rule = wr_rule_q;
  assign bus.wr_mask = wr_mask_q;
  assign bus.srch_issue = issue_q;
  assign bus.upd_done = done_q;
  assign bus.busy = state_q != IDLE || done_q;
endmodule

// File: tb/tb_fractcam_upd_ctrl.sv
// tb_fractcam_upd_ctrl: table, directed and random checks of the FRACTCAM front-end controller
module tb_fractcam_upd_ctrl;
  localparam int LAT = 3;
  localparam logic [39:0] K = 40'h0842108421;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int applied = 0;
  int miscompares = 0;
  int cyc, last_issue, ws;
  bit pri, act;
  logic [39:0] hold, rule, mask, obs_key;
  logic [2:0] blk;
  logic obs_we, obs_done, obs_issue, obs_busy, obs_sr, obs_ur;
  logic [3:0] obs_sel;

  fractcam_upd_ctrl_if #(.key_size(40), .SN(4), .BW(3)) bus ();
  fractcam_upd_ctrl #(.key_size(40), .SN(4), .LW(5), .SRCH_LAT(LAT), .BW(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sv; logic [39:0] sk; logic uv; logic [2:0] ub; logic [39:0] ur; logic [39:0] um;
    logic e_iss; logic [39:0] e_key; logic e_we; logic [3:0] e_sel; logic e_busy; logic e_sr; logic e_ur;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    applied++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, a, e);
    end
  endtask

  function automatic logic [39:0] rk();
    return {8'($urandom), $urandom};
  endfunction

  task automatic set_in(input logic sv, input logic [39:0] sk, input logic uv, input logic [2:0] ub,
                        input logic [39:0] ur, input logic [39:0] um);
    bus.s_valid = sv;
    bus.s_key = sk;
    bus.u_valid = uv;
    bus.u_blk = ub;
    bus.u_rule = ur;
    bus.u_mask = um;
  endtask

  task automatic model_reset();
    pri = 0;
    act = 0;
    hold = '0;
    rule = '0;
    mask = '0;
    blk = '0;
    last_issue = -100;
    ws = 0;
  endtask

  task automatic rst_check();
    #1;
    chk("rst_key", 64'(bus.key), 0);
    chk("rst_sel", 64'(bus.sel), 0);
    chk("rst_we", 64'(bus.we), 0);
    chk("rst_wr_rule", 64'(bus.wr_rule), 0);
    chk("rst_wr_mask", 64'(bus.wr_mask), 0);
    chk("rst_issue", 64'(bus.srch_issue), 0);
    chk("rst_done", 64'(bus.upd_done), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_s_ready", 64'(bus.s_ready), 0);
    chk("rst_u_ready", 64'(bus.u_ready), 0);
  endtask

  // One cycle: compare against the timeline model, then advance it by the accepted requests.
  task automatic step();
    bit wr, dn, idle, esr, eur;
    int cnt, w;
    logic [39:0] ek;
    logic [3:0] esel;
    #1;
    wr = act && cyc >= ws && cyc < ws + 32;
    dn = act && cyc == ws + 32;
    idle = !act || dn;
    cnt = cyc - ws;
    ek = wr ? 40'(cnt) * K : hold;
    esel = (wr && blk < 4) ? 4'(1 << blk) : 4'b0;
    esr = idle && !(bus.u_valid && pri);
    eur = idle && bus.u_valid && (pri || !bus.s_valid);
    obs_we = bus.we; obs_done = bus.upd_done; obs_issue = bus.srch_issue; obs_busy = bus.busy;
    obs_sr = bus.s_ready; obs_ur = bus.u_ready; obs_sel = bus.sel; obs_key = bus.key;
    chk("s_ready", 64'(bus.s_ready), 64'(esr));
    chk("u_ready", 64'(bus.u_ready), 64'(eur));
    chk("key", 64'(bus.key), 64'(ek));
    chk("sel", 64'(bus.sel), 64'(esel));
    chk("we", 64'(bus.we), 64'(wr));
    chk("srch_issue", 64'(bus.srch_issue), 64'(last_issue == cyc));
    chk("upd_done", 64'(bus.upd_done), 64'(dn));
    chk("busy", 64'(bus.busy), 64'(act));
    chk("wr_rule", 64'(bus.wr_rule), 64'(rule));
    chk("wr_mask", 64'(bus.wr_mask), 64'(mask));
    if (wr) hold = ek;
    if (dn) act = 0;
    if (bus.s_valid && esr) begin
      last_issue = cyc + 1;
      hold = bus.s_key;
      pri = 1;
    end
    if (bus.u_valid && eur) begin
      pri = 0;
      rule = bus.u_rule;
      mask = bus.u_mask;
      blk = bus.u_blk;
      act = 1;
      w = cyc + 2;
      if (last_issue + LAT + 2 > w) w = last_issue + LAT + 2;
      ws = w;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain_idle();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200 && act; i++) step();
    chk("idle_timeout", 64'(bus.busy), 0);
  endtask

  initial begin
    int a, done_at, we_n, sel_n, iss, bsy, sacc, dr, sr_bad, dn, wseen;
    logic [39:0] key1;
    tbl[0] = '{1'b1, 40'h123456789A, 1'b0, 3'd0, 40'h0, 40'h0,  1'b0, 40'h0,          1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 40'h1111111111, 1'b0, 3'd0, 40'h0, 40'h0,  1'b1, 40'h123456789A, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 40'h0,          1'b0, 3'd0, 40'h0, 40'h0,  1'b1, 40'h1111111111, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 40'h0,          1'b1, 3'd2, 40'hAA, 40'h0F, 1'b0, 40'h1111111111, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 40'h0,          1'b0, 3'd0, 40'h0, 40'h0,  1'b0, 40'h1111111111, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 40'hFF,         1'b0, 3'd0, 40'h0, 40'h0,  1'b0, 40'h1111111111, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 40'h0,          1'b0, 3'd0, 40'h0, 40'h0,  1'b0, 40'h1111111111, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 40'h0,          1'b0, 3'd0, 40'h0, 40'h0,  1'b0, 40'h0,          1'b1, 4'h4, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 40'h0,          1'b0, 3'd0, 40'h0, 40'h0,  1'b0, 40'h0842108421, 1'b1, 4'h4, 1'b1, 1'b0, 1'b0};
    cyc = 0;
    model_reset();
    set_in(1, 40'h123456789A, 1, 3'd2, 40'hAA, 40'h0F);
    repeat (2) @(negedge clk);
    rst_check();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].sv, tbl[i].sk, tbl[i].uv, tbl[i].ub, tbl[i].ur, tbl[i].um);
      #1;
      chk("tbl_issue", 64'(bus.srch_issue), 64'(tbl[i].e_iss));
      chk("tbl_key", 64'(bus.key), 64'(tbl[i].e_key));
      chk("tbl_we", 64'(bus.we), 64'(tbl[i].e_we));
      chk("tbl_sel", 64'(bus.sel), 64'(tbl[i].e_sel));
      chk("tbl_busy", 64'(bus.busy), 64'(tbl[i].e_busy));
      chk("tbl_s_ready", 64'(bus.s_ready), 64'(tbl[i].e_sr));
      chk("tbl_u_ready", 64'(bus.u_ready), 64'(tbl[i].e_ur));
      step();
    end
    drain_idle();
    idle_steps(3);
    iss = 0;
    bsy = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, rk(), 0, 0, 0, 0);
      step();
      iss += int'(obs_issue);
      bsy += int'(obs_busy);
    end
    idle_steps(1);
    iss += int'(obs_issue);
    idle_steps(1);
    iss += int'(obs_issue);
    chk("b2b_issues", 64'(iss), 10);
    chk("b2b_busy", 64'(bsy), 0);
    idle_steps(5);
    a = cyc;
    set_in(0, 0, 1, 3'd2, 40'hAA, 40'h0F);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    done_at = -1;
    we_n = 0;
    sel_n = 0;
    key1 = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs_we) begin
        we_n++;
        if (obs_sel == 4'b0100) sel_n++;
        if (we_n == 2) key1 = obs_key;
      end
      if (obs_done && done_at < 0) done_at = cyc - 1;
    end
    chk("upd_we_cycles", 64'(we_n), 32);
    chk("upd_sel_cycles", 64'(sel_n), 32);
    chk("upd_key_cnt1", 64'(key1), 64'h0842108421);
    chk("upd_done_lat", 64'(done_at - a), 34);
    set_in(1, rk(), 1, 3'd3, 40'h5555, 40'h3);
    sacc = 0;
    dn = 0;
    for (int i = 0; i < 10 && dn == 0; i++) begin
      bus.s_key = rk();
      step();
      if (obs_ur) dn = 1;
      else if (obs_sr) sacc++;
    end
    chk("cont_srch_before_upd", 64'(sacc), 1);
    chk("cont_upd_accepted", 64'(dn), 1);
    bus.u_valid = 1'b0;
    dr = 0;
    sr_bad = 0;
    dn = 0;
    wseen = 0;
    for (int i = 0; i < 60 && dn == 0; i++) begin
      bus.s_key = rk();
      step();
      if (obs_we) wseen = 1;
      if (obs_busy && !obs_we && wseen == 0) dr++;
      if (obs_sr && !obs_done) sr_bad++;
      if (obs_done) dn = 1;
    end
    chk("cont_drain_cycles", 64'(dr), 4);
    chk("cont_s_ready_busy", 64'(sr_bad), 0);
    chk("cont_done", 64'(dn), 1);
    drain_idle();
    idle_steps(5);
    set_in(0, 0, 1, 3'd5, rk(), rk());
    step();
    set_in(0, 0, 0, 0, 0, 0);
    we_n = 0;
    sel_n = 0;
    dn = 0;
    for (int i = 0; i < 60 && dn == 0; i++) begin
      step();
      if (obs_we) we_n++;
      if (obs_we && obs_sel == 4'b0) sel_n++;
      if (obs_done) dn = 1;
    end
    chk("inv_we_cycles", 64'(we_n), 32);
    chk("inv_sel_zero", 64'(sel_n), 32);
    chk("inv_done", 64'(dn), 1);
    drain_idle();
    idle_steps(5);
    set_in(0, 0, 1, 3'd1, rk(), rk());
    step();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60 && !(act && cyc == ws + 10); i++) step();
    chk("mwr_we_before", 64'(bus.we), 1);
    chk("mwr_key_cnt10", 64'(bus.key), 64'(40'd10 * K));
    #2;
    reset = 1'b0;
    #1;
    chk("mwr_we", 64'(bus.we), 0);
    chk("mwr_sel", 64'(bus.sel), 0);
    chk("mwr_busy", 64'(bus.busy), 0);
    chk("mwr_done", 64'(bus.upd_done), 0);
    repeat (2) begin
      @(negedge clk);
      rst_check();
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      idle_steps(1);
      dn += int'(obs_done);
    end
    chk("mwr_no_done", 64'(dn), 0);
    set_in(1, 40'hCAFEBABE12, 0, 0, 0, 0);
    step();
    idle_steps(1);
    chk("mwr_post_issue", 64'(obs_issue), 1);
    chk("mwr_post_key", 64'(obs_key), 64'hCAFEBABE12);
    for (int i = 0; i < 1500; i++) begin
      set_in($urandom_range(0, 9) < 6, rk(), $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)), rk(), rk());
      step();
    end
    drain_idle();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
